// File: rtl/bcd_scan_driver_pkg.sv
// Shared constants, state encoding and the shift-add-3 step for the BCD scan driver.
package bcd_scan_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_e;

    localparam logic [3:0] AN_ONES     = 4'b1110;
    localparam logic [3:0] AN_TENS     = 4'b1101;
    localparam logic [3:0] BCD_BLANK   = 4'b1111;
    localparam logic [6:0] MAX_DISPLAY = 7'd99;

    localparam int         BIN_BITS  = 7;
    localparam int         BCD_BITS  = 8;
    localparam int         SHIFT_W   = BCD_BITS + BIN_BITS;
    localparam logic [2:0] ITER_LAST = 3'd6;

    // Layout of the working register: {tens[14:11], ones[10:7], bin[6:0]}.
    function automatic logic [SHIFT_W-1:0] dabble_step(input logic [SHIFT_W-1:0] s);
        logic [SHIFT_W-1:0] t;
        t = s;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[SHIFT_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_scan_driver_anode_scan.sv
// Free-running refresh counter that alternates the anode select between the ones and tens digit.
module anode_scan
    import bcd_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] an
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tens_q, tens_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tens_d = tens_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tens_d = ~tens_q;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tens_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tens_q <= tens_d;
        end
    end

    // Decoding from a single bit keeps an restricted to the two legal patterns.
    assign an = tens_q ? AN_TENS : AN_ONES;

endmodule

// File: rtl/bcd_scan_driver.sv
// Sequential binary-to-BCD converter with a glitch-free display buffer and anode scan.
module bcd_scan_driver
    import bcd_scan_driver_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BIN_W       = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [3:0]       first,
    output logic [3:0]       second,
    output logic [3:0]       an
);

    state_e               state_q, state_d;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic [BIN_BITS-1:0]  val_q, val_d;
    logic [2:0]           iter_q, iter_d;
    logic [3:0]           first_q, first_d;
    logic [3:0]           second_q, second_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        val_d    = val_q;
        iter_d   = iter_q;
        first_d  = first_q;
        second_d = second_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The cycle that shows done must not accept a new request.
                if (load && !done_q) begin
                    shift_d = {{BCD_BITS{1'b0}}, bin_in};
                    val_d   = bin_in;
                    iter_d  = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shift_d = dabble_step(shift_q);
                iter_d  = iter_q + 3'd1;
                if (iter_q == ITER_LAST) state_d = UPDATE;
            end
            UPDATE: begin
                if (val_q > MAX_DISPLAY) begin
                    first_d  = BCD_BLANK;
                    second_d = BCD_BLANK;
                    ovf_d    = 1'b1;
                end else begin
                    first_d  = shift_q[10:7];
                    second_d = shift_q[14:11];
                    ovf_d    = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            val_q    <= '0;
            iter_q   <= '0;
            first_q  <= '0;
            second_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            val_q    <= val_d;
            iter_q   <= iter_d;
            first_q  <= first_d;
            second_q <= second_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overflow = ovf_q;
    assign first    = first_q;
    assign second   = second_q;

    anode_scan #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_anode_scan (
        .clk  (clk),
        .rst_n(rst_n),
        .an   (an)
    );

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench: cycle-level behavioural model plus directed and random load traffic.
module tb_bcd_scan_driver;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] bin_in = '0;
    logic       load = 1'b0;
    logic       busy, done, overflow;
    logic [3:0] first, second, an;

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;

    bcd_scan_driver #(.REFRESH_DIV(DIV), .BIN_W(7)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bin_in  (bin_in),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .first   (first),
        .second  (second),
        .an      (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Behavioural model: a request occupies the converter for 8 cycles, then the
    // buffer takes value%10 / value/10 (or blanks above 99) with a one-cycle done.
    int         m_cyc, m_pending;
    logic [6:0] m_val;
    logic [3:0] m_first, m_second;
    logic       m_ovf, m_done, m_was_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_pending = 0; m_val = '0;
            m_first = '0; m_second = '0; m_ovf = 0; m_done = 0;
        end else begin
            m_was_done = m_done;
            m_done = 0;
            m_cyc++;
            if (m_pending > 0) begin
                m_pending--;
                if (m_pending == 0) begin
                    if (int'(m_val) > 99) begin
                        m_first = 4'hF; m_second = 4'hF; m_ovf = 1;
                    end else begin
                        m_first  = 4'(int'(m_val) % 10);
                        m_second = 4'(int'(m_val) / 10);
                        m_ovf    = 0;
                    end
                    m_done = 1;
                end
            end else if (load && !m_was_done) begin
                m_pending = 8;
                m_val = bin_in;
            end
        end
    end

    function automatic logic [3:0] model_an(input int cyc);
        return ((cyc / DIV) % 2 == 1) ? 4'b1101 : 4'b1110;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("an", {4'd0, an}, {4'd0, model_an(m_cyc)});
            check("busy", {7'd0, busy}, {7'd0, (m_pending > 0)});
            check("done", {7'd0, done}, {7'd0, m_done});
            check("overflow", {7'd0, overflow}, {7'd0, m_ovf});
            check("first", {4'd0, first}, {4'd0, m_first});
            check("second", {4'd0, second}, {4'd0, m_second});
            if (done) done_cnt++;
        end
    end

    task automatic do_load(input logic [6:0] v, output int lat);
        @(negedge clk);
        bin_in = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic expect_digits(input string name, input logic [6:0] v,
                                 input logic [3:0] tens, input logic [3:0] ones,
                                 input logic ovf);
        int lat;
        do_load(v, lat);
        check({name, "_latency"}, 8'(lat), 8'd9);
        check({name, "_second"}, {4'd0, second}, {4'd0, tens});
        check({name, "_first"}, {4'd0, first}, {4'd0, ones});
        check({name, "_ovf"}, {7'd0, overflow}, {7'd0, ovf});
    endtask

    initial begin
        int d0;
        #2;
        check("rst_an", {4'd0, an}, 8'b0000_1110);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_first", {4'd0, first}, 8'd0);
        check("rst_second", {4'd0, second}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Anode pattern: 4 cycles ones, 4 cycles tens.
        @(negedge clk);
        check("scan_c1", {4'd0, an}, 8'b0000_1110);
        repeat (4) @(negedge clk);
        check("scan_c5", {4'd0, an}, 8'b0000_1101);
        repeat (4) @(negedge clk);
        check("scan_c9", {4'd0, an}, 8'b0000_1110);

        expect_digits("v57", 7'd57, 4'd5, 4'd7, 1'b0);
        expect_digits("v0", 7'd0, 4'd0, 4'd0, 1'b0);
        expect_digits("v99", 7'd99, 4'd9, 4'd9, 1'b0);
        expect_digits("v9", 7'd9, 4'd0, 4'd9, 1'b0);
        expect_digits("v100", 7'd100, 4'hF, 4'hF, 1'b1);
        expect_digits("v127", 7'd127, 4'hF, 4'hF, 1'b1);
        expect_digits("v42", 7'd42, 4'd4, 4'd2, 1'b0);

        // Load held into the done cycle must be ignored.
        load = 1'b1;
        bin_in = 7'd77;
        @(negedge clk);
        load = 1'b0;
        check("load_on_done_busy", {7'd0, busy}, 8'd0);

        // Load during busy is dropped.
        d0 = done_cnt;
        @(negedge clk);
        bin_in = 7'd57; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        bin_in = 7'd33; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("busy_load_dones", 8'(done_cnt - d0), 8'd1);
        check("busy_load_second", {4'd0, second}, 8'd5);
        check("busy_load_first", {4'd0, first}, 8'd7);

        // Reset in the middle of a conversion.
        d0 = done_cnt;
        @(negedge clk);
        bin_in = 7'd88; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        check("abort_first", {4'd0, first}, 8'd0);
        check("abort_second", {4'd0, second}, 8'd0);
        check("abort_an", {4'd0, an}, 8'b0000_1110);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("abort_no_done", 8'(done_cnt - d0), 8'd0);
        expect_digits("v12", 7'd12, 4'd1, 4'd2, 1'b0);

        // Random traffic with loads landing anywhere, including while busy.
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0:       bin_in = 7'd99;
                1:       bin_in = 7'd100;
                default: bin_in = 7'($urandom_range(0, 127));
            endcase
        end
        @(negedge clk);
        load = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
